// File: rtl/count_stream_checker.sv
// count_stream_checker: watches a free-running count byte, checks every change is +1 and locks onto its interval.
// Latency: din is registered once, then compared; last_val and error flags update 2 clocks after din changes.
// Backpressure: none, it is a pure observer; en=0 freezes the monitor while din_q keeps sampling.
//
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   din          : observed count byte
//   en           : monitor enable (0 = hold all state except din_q)
//   clr          : synchronous return to IDLE with all outputs cleared; wins over en
//   last_val     : last accepted din value
//   period_o     : currently measured change interval in clk cycles
//   locked       : high while tracking a stable interval
//   err_step     : one-cycle pulse when a change is not exactly +1
//   err_period   : one-cycle pulse when a locked interval is violated (early, late or missing change)
//   err_count    : saturating count of cycles with any error pulse
module count_stream_checker #(
  parameter int DW     = 8,
  parameter int PW     = 32,
  parameter int LOCK_N = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          en,
  input  logic          clr,
  output logic [DW-1:0] last_val,
  output logic [PW-1:0] period_o,
  output logic          locked,
  output logic          err_step,
  output logic          err_period,
  output logic [15:0]   err_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACQ   = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  localparam logic [3:0]    LOCK_C  = 4'(LOCK_N);
  localparam logic [PW-1:0] GAP_MAX = '1;

  state_t        state_q, state_d;
  logic [DW-1:0] din_q;
  logic [DW-1:0] last_val_q, last_val_d;
  logic [PW-1:0] gap_q, gap_d;
  logic [PW-1:0] period_q, period_d;
  logic [3:0]    match_q, match_d;
  // Set on every entry to ACQ that has no usable previous change: the next
  // change only restarts the gap and is not taken as an interval sample.
  logic          first_q, first_d;
  logic          err_step_q, err_step_d;
  logic          err_period_q, err_period_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic [PW-1:0] interval;
  logic [DW-1:0] last_inc;
  logic [3:0]    match_inc;
  logic          chg;
  logic          step_ok;

  // Interval of a change seen this cycle; doubles as the saturating gap
  // increment, so a saturated gap reports an all-ones interval.
  assign interval  = (gap_q == GAP_MAX) ? GAP_MAX : gap_q + PW'(1);
  assign last_inc  = last_val_q + DW'(1);
  assign match_inc = match_q + 4'd1;
  assign chg       = (state_q != S_IDLE) && (din_q != last_val_q);
  assign step_ok   = (din_q == last_inc);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else if (clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath decode
  always_comb begin
    state_d      = state_q;
    last_val_d   = last_val_q;
    gap_d        = gap_q;
    match_d      = match_q;
    period_d     = period_q;
    first_d      = first_q;
    err_step_d   = 1'b0;
    err_period_d = 1'b0;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          last_val_d = din_q;
          gap_d      = '0;
          match_d    = '0;
          first_d    = 1'b1;
          state_d    = S_ACQ;
        end
        default: begin
          if (chg) begin
            last_val_d = din_q;
            gap_d      = '0;
            if (!step_ok) begin
              // A bad step never feeds the interval measurement.
              err_step_d = 1'b1;
              if ((state_q == S_TRACK) && (interval != period_q)) begin
                err_period_d = 1'b1;
              end
              match_d = '0;
              first_d = 1'b1;
              state_d = S_ACQ;
            end else if (state_q == S_ACQ) begin
              if (first_q) begin
                first_d = 1'b0;
              end else if (interval == period_q) begin
                match_d = match_inc;
                if (match_inc >= LOCK_C) begin
                  state_d = S_TRACK;
                end
              end else begin
                period_d = interval;
                match_d  = 4'd1;
                if (LOCK_C == 4'd1) begin
                  state_d = S_TRACK;
                end
              end
            end else if (interval != period_q) begin
              // Early or late change while tracking: adopt it as the first sample of a new period.
              err_period_d = 1'b1;
              period_d     = interval;
              match_d      = 4'd1;
              first_d      = 1'b0;
              state_d      = S_ACQ;
            end
          end else begin
            gap_d = interval;
            // Expected change did not arrive: flag once and reacquire;
            // the gap keeps running so the eventual change is ignored as a sample.
            if ((state_q == S_TRACK) && (interval == period_q)) begin
              err_period_d = 1'b1;
              match_d      = '0;
              first_d      = 1'b1;
              state_d      = S_ACQ;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((err_step_d || err_period_d) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q        <= '0;
      last_val_q   <= '0;
      gap_q        <= '0;
      period_q     <= '0;
      match_q      <= '0;
      first_q      <= 1'b0;
      err_step_q   <= 1'b0;
      err_period_q <= 1'b0;
      err_cnt_q    <= '0;
    end else if (clr) begin
      din_q        <= '0;
      last_val_q   <= '0;
      gap_q        <= '0;
      period_q     <= '0;
      match_q      <= '0;
      first_q      <= 1'b0;
      err_step_q   <= 1'b0;
      err_period_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      din_q        <= din;
      last_val_q   <= last_val_d;
      gap_q        <= gap_d;
      period_q     <= period_d;
      match_q      <= match_d;
      first_q      <= first_d;
      err_step_q   <= err_step_d;
      err_period_q <= err_period_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Outputs
  always_comb begin
    locked = (state_q == S_TRACK);
  end

  assign last_val   = last_val_q;
  assign period_o   = period_q;
  assign err_step   = err_step_q;
  assign err_period = err_period_q;
  assign err_count  = err_cnt_q;

endmodule

// File: doc/count_stream_checker.md
Name: count_stream_checker

Overview:
- Receive-side monitor for the 8-bit free-running count byte that `core` drives on `dummy_out`, where that byte is the top byte of core's 32-bit counter.
- Observes the byte stream and checks every value change is exactly +1, modulo 2^DW.
- Measures the interval between changes and locks onto it. Once locked, it flags any change that arrives late or early.
- Sits beside core at top level as a built-in self-check. Status outputs go to top-level pins or a debug readout.

Parameters:
- DW, 8, width of the observed count byte.
- PW, 32, width of the interval counter and of period_o.
- LOCK_N, 2, number of consecutive equal intervals needed to enter TRACK (range 1..15).

Ports:
- clk, input, 1, single system clock.
- rst_n, input, 1, asynchronous active-low reset.
- din, input, DW, observed count value (core's dummy_out).
- en, input, 1, monitor enable; when 0, all state holds.
- clr, input, 1, synchronous clear of the monitor to IDLE; priority over en.
- last_val, output, DW, last accepted din value.
- period_o, output, PW, currently measured interval in cycles.
- locked, output, 1, high while in TRACK.
- err_step, output, 1, one-cycle pulse on a bad increment.
- err_period, output, 1, one-cycle pulse on an interval violation while locked.
- err_count, output, 16, saturating count of error cycles.

Behaviour:
- Reset (rst_n=0, asynchronous): everything below takes its reset value.
  - State = IDLE; din_q = 0; gap = 0; match count = 0.
  - last_val = 0, period_o = 0, locked = 0, err_step = 0, err_period = 0, err_count = 0.
- Input pipeline and latency:
  - din is registered into din_q every cycle, regardless of en.
  - A change is detected when en=1, state != IDLE, and din_q != last_val.
  - Outputs are registered, so flags and last_val update 2 clocks after din changes.
- gap counter: increments each en=1 cycle in ACQ/TRACK with no change; saturates at all-ones. On a change cycle: interval = gap+1, then gap <= 0.
- clr=1: same effect as reset, applied synchronously on the next edge, including err_count = 0.
- en=0: all registers except din_q hold; error pulses deassert.
- IDLE: on en=1, last_val <= din_q, gap <= 0, match count <= 0, go to ACQ.
- Step check (ACQ and TRACK), on every change:
  - Valid if din_q == last_val + 1 mod 2^DW; wrap from 0xFF to 0x00 is valid.
  - last_val <= din_q in all cases.
  - Invalid step: err_step pulses; match count <= 0; locked <= 0; state <= ACQ; this change is not used as an interval sample.
- ACQ:
  - On the first valid change after entering ACQ: no interval sample; only gap restarts.
  - On later valid changes: if interval == period_o, match count increments; otherwise period_o <= interval and match count <= 1.
  - When match count reaches LOCK_N: state <= TRACK, locked <= 1 on the same edge.
- TRACK:
  - Valid change with interval == period_o: no action.
  - Valid change with interval != period_o: err_period pulses, period_o <= interval, match count <= 1, state <= ACQ, locked <= 0.
  - Timeout: if gap+1 == period_o and no change this cycle, err_period pulses once, state <= ACQ, locked <= 0, gap continues counting. The next change then counts as the first change after entering ACQ.
- Simultaneous bad step and interval mismatch: both flags pulse in the same cycle; err_count increments by 1.
- err_count: +1 on any cycle where err_step or err_period asserts; saturates at 0xFFFF, never wraps.
- period_o saturation: if gap saturates, the interval equals the all-ones PW value; no special flag.

Test Plan:
1. Reset, en=1, din increments by 1 every 4 cycles starting at 0x10 → period_o=4; locked=1 after the 3rd change (LOCK_N=2); no error pulses; err_count=0.
2. Locked at period 4, din steps 0xFE→0xFF→0x00→0x01 on schedule → no errors; last_val=0x01; locked stays 1.
3. Locked at period 4, din jumps 0x20→0x22 → err_step high for exactly 1 cycle, 2 clocks after the jump; locked=0; err_count=1; relock after 3 further good changes.
4. Locked at period 4, din holds for 10 cycles → err_period pulses once, 4 cycles after the last change; locked=0; err_count=1. Resume with period 6 → period_o=6 and locked=1 again.
5. Locked, then en=0 for 20 cycles while din keeps changing, then en=1 → no errors during the hold. On resume, the first compare is against the held last_val, so a multi-step jump gives err_step=1.
6. err_count preloaded to 0xFFFE via repeated bad steps; two more bad steps → err_count saturates at 0xFFFF. Then clr=1 for 1 cycle → all outputs 0 and state IDLE. Assert rst_n=0 mid-ACQ → outputs clear immediately, without waiting for a clock edge.
